// File: rtl/ysyx_24100006_bus_pkg.sv
// Shared bus definitions for the ysyx_24100006 crossbars.
// Holds response codes, the read-crossbar state encoding and CLINT window constants.
package ysyx_24100006_bus_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] CLINT_BASE_DEFAULT = 32'h0200_0000;
   localparam logic [31:0] CLINT_MASK_DEFAULT = 32'hFFFF_F000;
   localparam logic [31:0] CLINT_BASE_NPC     = 32'hA000_0048;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_CLINT_REQ,
      RX_CLINT_WAIT,
      RX_MEM_AR,
      RX_MEM_R,
      RX_RESP
   } rxbar_state_e;

   function automatic logic addr_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/ysyx_24100006_rxbar_if.sv
// Read-channel interfaces: a full AXI-Lite style read port and the
// pulse-based CLINT read port (no arready, no rready, no rresp).
interface ysyx_24100006_rxbar_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (output araddr, arvalid, rready,
                   input  arready, rdata, rresp, rvalid);
   modport slave  (input  araddr, arvalid, rready,
                   output arready, rdata, rresp, rvalid);
endinterface

interface ysyx_24100006_clint_rd_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic [31:0] rdata;
   logic        rvalid;

   modport master (output araddr, arvalid,
                   input  rdata, rvalid);
   modport slave  (input  araddr, arvalid,
                   output rdata, rvalid);
endinterface

// File: rtl/ysyx_24100006_addr_dec.sv
// Combinational CLINT window decoder, shared by the read and write crossbars.
module ysyx_24100006_addr_dec
   import ysyx_24100006_bus_pkg::*;
#(
   parameter logic [31:0] BASE = CLINT_BASE_DEFAULT,
   parameter logic [31:0] MASK = CLINT_MASK_DEFAULT
) (
   input  logic [31:0] addr_i,
   output logic        clint_hit_o,
   output logic        misaligned_o
);

   assign clint_hit_o  = addr_hit(addr_i, BASE, MASK);
   assign misaligned_o = addr_i[1:0] != 2'b00;

endmodule

// File: rtl/ysyx_24100006_rxbar.sv
// LSU read crossbar: routes one outstanding read to CLINT or memory and
// buffers the response so the LSU sees a proper valid/ready handshake.
module ysyx_24100006_rxbar
   import ysyx_24100006_bus_pkg::*;
#(
   parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
   parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEFAULT
) (
   input logic                       clk,
   input logic                       reset,
   ysyx_24100006_rxbar_if.slave      lsu,
   ysyx_24100006_clint_rd_if.master  clint,
   ysyx_24100006_rxbar_if.master     mem
);

   rxbar_state_e state_q;
   logic [31:0]  addr_q;
   logic [31:0]  rdata_q;
   logic [1:0]   rresp_q;
   logic         arready_q;
   logic         clintArvalid_q;
   logic         memArvalid_q;
   logic         memRready_q;
   logic         rvalid_q;
   logic         clintHit;
   logic         misaligned;

   // Decoding the live address is only meaningful in the accepting cycle;
   // afterwards everything downstream works from addr_q.
   ysyx_24100006_addr_dec #(
      .BASE (CLINT_BASE),
      .MASK (CLINT_MASK)
   ) u_dec (
      .addr_i       (lsu.araddr),
      .clint_hit_o  (clintHit),
      .misaligned_o (misaligned)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RX_IDLE;
         addr_q         <= '0;
         rdata_q        <= '0;
         rresp_q        <= RESP_OKAY;
         arready_q      <= 1'b0;
         clintArvalid_q <= 1'b0;
         memArvalid_q   <= 1'b0;
         memRready_q    <= 1'b0;
         rvalid_q       <= 1'b0;
      end else begin
         case (state_q)
            RX_IDLE: begin
               if (!arready_q) begin
                  arready_q <= 1'b1;
               end else if (lsu.arvalid) begin
                  arready_q <= 1'b0;
                  addr_q    <= lsu.araddr;
                  if (clintHit && !misaligned) begin
                     clintArvalid_q <= 1'b1;
                     state_q        <= RX_CLINT_REQ;
                  end else if (clintHit) begin
                     rdata_q  <= '0;
                     rresp_q  <= RESP_SLVERR;
                     rvalid_q <= 1'b1;
                     state_q  <= RX_RESP;
                  end else begin
                     memArvalid_q <= 1'b1;
                     state_q      <= RX_MEM_AR;
                  end
               end
            end
            RX_CLINT_REQ: begin
               clintArvalid_q <= 1'b0;
               state_q        <= RX_CLINT_WAIT;
            end
            RX_CLINT_WAIT: begin
               if (clint.rvalid) begin
                  rdata_q  <= clint.rdata;
                  rresp_q  <= RESP_OKAY;
                  rvalid_q <= 1'b1;
                  state_q  <= RX_RESP;
               end
            end
            RX_MEM_AR: begin
               if (mem.arready) begin
                  memArvalid_q <= 1'b0;
                  memRready_q  <= 1'b1;
                  state_q      <= RX_MEM_R;
               end
            end
            RX_MEM_R: begin
               if (mem.rvalid) begin
                  memRready_q <= 1'b0;
                  rdata_q     <= mem.rdata;
                  rresp_q     <= mem.rresp;
                  rvalid_q    <= 1'b1;
                  state_q     <= RX_RESP;
               end
            end
            RX_RESP: begin
               if (lsu.rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  state_q   <= RX_IDLE;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign lsu.arready   = arready_q;
   assign lsu.rdata     = rdata_q;
   assign lsu.rresp     = rresp_q;
   assign lsu.rvalid    = rvalid_q;
   assign clint.araddr  = addr_q;
   assign clint.arvalid = clintArvalid_q;
   assign mem.araddr    = addr_q;
   assign mem.arvalid   = memArvalid_q;
   assign mem.rready    = memRready_q;

endmodule

// File: tb/tb_ysyx_24100006_rxbar.sv
// Self-checking bench for the read crossbar: each read is planned as a
// cycle timeline and every DUT output is compared against it each cycle.
module tb_ysyx_24100006_rxbar;

   localparam logic [31:0] CBASE = 32'h0200_0000;
   localparam logic [31:0] CMASK = 32'hFFFF_F000;
   localparam int KMIS   = 0;
   localparam int KCLINT = 1;
   localparam int KMEM   = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ysyx_24100006_rxbar_if    lsu ();
   ysyx_24100006_clint_rd_if clint ();
   ysyx_24100006_rxbar_if    mem ();

   ysyx_24100006_rxbar #(
      .CLINT_BASE (CBASE),
      .CLINT_MASK (CMASK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .lsu   (lsu),
      .clint (clint),
      .mem   (mem)
   );

   int nVec = 0;
   int nErr = 0;
   int cyc = 0;
   longint unsigned mtime;

   // Planned transaction timeline, in cycle numbers of the bench counter.
   bit          busy = 1'b0;
   bit          inReset = 1'b1;
   int          idleFrom = 0;
   int          relCyc = 0;
   int          tA, tKind, tS, tD, respStart, tH;
   logic [31:0] tAddr;
   logic [31:0] expData;
   logic [1:0]  expResp;
   int          clintPulses, memArvCycles, rvFirst;
   bit          rvSeen;
   logic [31:0] lastData;
   logic [1:0]  lastResp;
   bit          expArr, expClintArv, expMemArv, expMemRr, expRv;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge reset) begin
      if (reset) mtime <= 64'd0;
      else       mtime <= mtime + 64'd1;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Compare every DUT output against the planned timeline on each falling edge.
   always @(negedge clk) begin
      if (inReset) begin
         checkOutput("rst_arready", 64'(lsu.arready), 64'(0));
         checkOutput("rst_rvalid", 64'(lsu.rvalid), 64'(0));
         checkOutput("rst_rdata", 64'(lsu.rdata), 64'(0));
         checkOutput("rst_rresp", 64'(lsu.rresp), 64'(0));
         checkOutput("rst_clint_arvalid", 64'(clint.arvalid), 64'(0));
         checkOutput("rst_mem_arvalid", 64'(mem.arvalid), 64'(0));
         checkOutput("rst_mem_rready", 64'(mem.rready), 64'(0));
         checkOutput("rst_araddr", 64'(mem.araddr), 64'(0));
      end else begin
         expArr      = busy ? (cyc == tA) : (cyc >= idleFrom);
         expClintArv = busy && tKind == KCLINT && cyc == tA + 1;
         expMemArv   = busy && tKind == KMEM && cyc >= tA + 1 && cyc <= tA + 1 + tS;
         expMemRr    = busy && tKind == KMEM && cyc >= tA + 2 + tS && cyc <= tA + 2 + tS + tD;
         expRv       = busy && cyc >= respStart && cyc <= tH;
         checkOutput("arready", 64'(lsu.arready), 64'(expArr));
         checkOutput("clint_arvalid", 64'(clint.arvalid), 64'(expClintArv));
         checkOutput("mem_arvalid", 64'(mem.arvalid), 64'(expMemArv));
         checkOutput("mem_rready", 64'(mem.rready), 64'(expMemRr));
         checkOutput("rvalid", 64'(lsu.rvalid), 64'(expRv));
         if (expRv) begin
            checkOutput("rdata", 64'(lsu.rdata), 64'(expData));
            checkOutput("rresp", 64'(lsu.rresp), 64'(expResp));
            if (cyc == tH) begin
               lastData = lsu.rdata;
               lastResp = lsu.rresp;
            end
         end
         if (expClintArv) checkOutput("clint_araddr", 64'(clint.araddr), 64'(tAddr));
         if (expMemArv)   checkOutput("mem_araddr", 64'(mem.araddr), 64'(tAddr));
         if (clint.arvalid) clintPulses++;
         if (mem.arvalid)   memArvCycles++;
         if (lsu.rvalid && !rvSeen) begin
            rvSeen  = 1'b1;
            rvFirst = cyc;
         end
      end
   end

   task automatic idleInputs();
      lsu.arvalid   = 1'b0;
      lsu.rready    = 1'b0;
      clint.rvalid  = 1'b0;
      mem.arready   = 1'b0;
      mem.rvalid    = 1'b0;
   endtask

   // One read: plans the timeline, then plays the LSU and both slaves
   // cycle by cycle. abortAt >= 0 fires reset that many cycles after acceptance.
   task automatic applyStimulus(input logic [31:0] addr, input int s, input int d, input int low,
                                input logic [31:0] mdata, input logic [1:0] mresp, input int abortAt);
      bit hit;
      int kind;
      longint unsigned mt;
      while (cyc < idleFrom) begin
         @(posedge clk);
         #1;
      end
      hit  = (addr & CMASK) == CBASE;
      kind = !hit ? KMEM : (addr[1:0] != 2'b00 ? KMIS : KCLINT);
      tA = cyc; tKind = kind; tS = s; tD = d; tAddr = addr;
      respStart = (kind == KMIS) ? tA + 1 : (kind == KCLINT) ? tA + 3 : tA + 3 + s + d;
      tH = respStart + low;
      mt = longint'(tA + 2 - relCyc);
      if (kind == KMIS) begin
         expData = 32'd0; expResp = 2'b10;
      end else if (kind == KCLINT) begin
         expData = addr[2] ? mt[63:32] : mt[31:0]; expResp = 2'b00;
      end else begin
         expData = mdata; expResp = mresp;
      end
      clintPulses = 0; memArvCycles = 0; rvSeen = 1'b0; rvFirst = -1;
      busy = 1'b1;
      lsu.araddr  = addr;
      lsu.arvalid = 1'b1;
      while (cyc <= tH) begin
         if (cyc > tA) begin
            lsu.arvalid = 1'b0;
            lsu.araddr  = $urandom;
         end
         lsu.rready   = (low == 0) || (cyc >= respStart + low);
         clint.rvalid = (kind == KCLINT && cyc == tA + 2) || (kind != KMIS && cyc == tA + 1);
         clint.rdata  = (kind == KCLINT && cyc == tA + 2) ? (addr[2] ? mtime[63:32] : mtime[31:0]) : $urandom;
         mem.arready  = (kind == KMEM) && (cyc == tA + 1 + s);
         mem.rvalid   = (kind == KMEM) && (cyc == tA + 2 + s + d);
         mem.rdata    = mem.rvalid ? mdata : $urandom;
         mem.rresp    = mem.rvalid ? mresp : 2'($urandom);
         if (abortAt >= 0 && cyc == tA + abortAt) begin
            reset   = 1'b1;
            inReset = 1'b1;
            busy    = 1'b0;
            #1;
            checkOutput("abort_rvalid", 64'(lsu.rvalid), 64'(0));
            checkOutput("abort_mem_rready", 64'(mem.rready), 64'(0));
            checkOutput("abort_arready", 64'(lsu.arready), 64'(0));
            checkOutput("abort_araddr", 64'(mem.araddr), 64'(0));
            idleInputs();
            repeat (2) @(posedge clk);
            #1;
            reset    = 1'b0;
            inReset  = 1'b0;
            relCyc   = cyc;
            idleFrom = cyc + 1;
            return;
         end
         @(posedge clk);
         #1;
      end
      idleInputs();
      busy     = 1'b0;
      idleFrom = tH + 1;
   endtask

   initial begin
      logic [31:0] a;
      lsu.araddr = 32'd0; clint.rdata = 32'd0; mem.rdata = 32'd0; mem.rresp = 2'b00;
      idleInputs();
      repeat (3) @(posedge clk);
      #1;
      reset    = 1'b0;
      inReset  = 1'b0;
      relCyc   = cyc;
      idleFrom = cyc + 1;
      while (cyc < relCyc + 100) begin
         @(posedge clk);
         #1;
      end

      applyStimulus(32'h0200_0000, 0, 0, 0, 32'd0, 2'b00, -1);
      checkOutput("mtime_lo_data", 64'(lastData), 64'd102);
      checkOutput("mtime_lo_resp", 64'(lastResp), 64'd0);
      checkOutput("mtime_lo_pulses", 64'(clintPulses), 64'd1);
      checkOutput("mtime_lo_latency", 64'(rvFirst - tA), 64'd3);

      applyStimulus(32'h0200_0004, 0, 0, 0, 32'd0, 2'b00, -1);
      checkOutput("mtime_hi_data", 64'(lastData), 64'd0);
      checkOutput("mtime_hi_mem_idle", 64'(memArvCycles), 64'd0);

      applyStimulus(32'h8000_0010, 4, 1, 0, 32'hDEAD_BEEF, 2'b10, -1);
      checkOutput("mem_data", 64'(lastData), 64'hDEAD_BEEF);
      checkOutput("mem_resp", 64'(lastResp), 64'd2);
      checkOutput("mem_ar_cycles", 64'(memArvCycles), 64'd5);
      checkOutput("mem_latency", 64'(rvFirst - tA), 64'd8);

      applyStimulus(32'h0200_0008, 0, 0, 5, 32'd0, 2'b00, -1);
      checkOutput("hold_pulses", 64'(clintPulses), 64'd1);

      applyStimulus(32'h0200_0002, 0, 0, 0, 32'd0, 2'b00, -1);
      checkOutput("mis_data", 64'(lastData), 64'd0);
      checkOutput("mis_resp", 64'(lastResp), 64'd2);
      checkOutput("mis_no_clint", 64'(clintPulses), 64'd0);
      checkOutput("mis_no_mem", 64'(memArvCycles), 64'd0);
      checkOutput("mis_latency", 64'(rvFirst - tA), 64'd1);

      applyStimulus(32'h8000_0100, 0, 20, 0, 32'h1234_5678, 2'b00, 5);
      applyStimulus(32'h0200_0000, 0, 0, 0, 32'd0, 2'b00, -1);
      checkOutput("post_rst_pulses", 64'(clintPulses), 64'd1);
      checkOutput("post_rst_latency", 64'(rvFirst - tA), 64'd3);
      checkOutput("post_rst_resp", 64'(lastResp), 64'd0);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: a = CBASE | (32'($urandom_range(0, 1023)) << 2);
            4:          a = CBASE | (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
            default: begin
               a = $urandom;
               if ((a & CMASK) == CBASE) a[31] = 1'b1;
            end
         endcase
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         applyStimulus(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom, 2'($urandom), -1);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
